mul_unit_arbiter: RTL and testbench
===================================

MUL_UNIT_ARBITER -- requirements
Module: mul_unit_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: cycles WAIT tolerates without unit_vld before abort; legal range 2..255.
REQ-002 SHALL have parameter NAN_WORD, default 32'h7FC00000: result returned on abort (IEEE754 quiet NaN).
REQ-003 sys_clk  input  1  sole clock; all state on its rising edge.
REQ-004 sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid  input  1  requester 0 (multiplier) operands pending; held until accepted.
REQ-006 req0_data1, req0_data2  input  32 each  requester 0 operands.
REQ-007 req0_ready  output  1  combinational grant; transfer when req0_valid & req0_ready.
REQ-008 req0_result  output  32  result for requester 0.
REQ-009 req0_vld  output  1  one-cycle pulse, req0_result valid.
REQ-010 req1_valid, req1_data1, req1_data2, req1_ready, req1_result, req1_vld: same as REQ-005..009 for requester 1 (divider).
REQ-011 unit_data1, unit_data2  output  32 each  registered operands to shared multiplier unit.
REQ-012 unit_trig  output  1  registered one-cycle start pulse to unit.
REQ-013 unit_result  input  32  unit result; unit_vld  input  1  result-valid pulse.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 err  output  1  one-cycle pulse with the reqN_vld of an aborted (timed-out) operation.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE.
REQ-017 IDLE: reqN_ready high only for the granted requester; at most one ready high per cycle; both low in ISSUE/WAIT.
REQ-018 Grant: only one valid -> that one; both valid -> requester not in last_grant (round robin); last_grant updates on each transfer.
REQ-019 On transfer at cycle T: capture operands into unit_data1/2, record owner, go ISSUE; unit_trig = 1 during T+1 only.
REQ-020 ISSUE always -> WAIT next cycle; wait counter cleared to 0.
REQ-021 unit_data1/2 SHALL stay stable from T+1 until the operation completes.
REQ-022 WAIT: counter increments each cycle without unit_vld.
REQ-023 unit_vld in WAIT at cycle V: owner_result <= unit_result, owner_vld = 1 during V+1, state IDLE at V+1; a new grant is allowed at V+1.
REQ-024 Timeout: counter reaches TIMEOUT-1 with no unit_vld -> owner_result <= NAN_WORD, owner_vld and err pulse next cycle, state IDLE.
REQ-025 unit_vld and timeout in the same cycle: unit_vld wins, no err.
REQ-026 unit_vld while in IDLE or ISSUE SHALL be ignored (no vld, no state change).
REQ-027 reqN_result SHALL hold its last value until overwritten by that requester's next completion.
REQ-028 Non-owner vld stays 0; only one of req0_vld/req1_vld may pulse per cycle.
REQ-029 Deasserting reqN_valid before acceptance SHALL withdraw the request without side effects.

Reset
REQ-030 Asynchronous reset SHALL force: state IDLE, last_grant = 1 (requester 0 wins first tie), counter 0, unit_trig 0, unit_data1/2 0, req0/1_result 0, req0/1_vld 0, err 0, busy 0, ready outputs follow IDLE grant rules.
REQ-031 Reset mid-operation SHALL abandon the operation with no vld pulse; a later stray unit_vld is ignored per REQ-026.

Verification
REQ-032 Single req0: req0_valid, operands 3F800000/40000000 at T -> req0_ready at T, unit_trig at T+1 with those operands; unit_vld = 40000000 at T+5 -> req0_vld, req0_result 40000000 at T+6, busy low at T+6.
REQ-033 Contention: both valid from reset -> req0 granted first; after completion req1 granted at the completion cycle; with both still valid, grants alternate 0,1,0,1.
REQ-034 Timeout: TIMEOUT=8, no unit_vld -> req1_vld, err, req1_result 7FC00000 exactly 8 cycles after the unit_trig cycle.
REQ-035 Race: unit_vld on the final timeout cycle -> normal result delivered, err stays 0.
REQ-036 Reset in WAIT, then unit_vld 2 cycles after release -> no vld, state IDLE, all outputs at reset values.
REQ-037 Stray unit_vld in IDLE and in ISSUE -> no vld pulses, operation in ISSUE completes normally.

Source files
------------

// File: rtl/mul_unit_arbiter_if.sv
// Bundle of signals between two requesters, the arbiter and the shared multiplier unit.
// The arbiter connects through the slave modport; the environment driving it uses master.
interface mul_unit_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_data1;
  logic [31:0] req0_data2;
  logic        req0_ready;
  logic [31:0] req0_result;
  logic        req0_vld;

  logic        req1_valid;
  logic [31:0] req1_data1;
  logic [31:0] req1_data2;
  logic        req1_ready;
  logic [31:0] req1_result;
  logic        req1_vld;

  logic [31:0] unit_data1;
  logic [31:0] unit_data2;
  logic        unit_trig;
  logic [31:0] unit_result;
  logic        unit_vld;

  logic        busy;
  logic        err;

  modport slave (
    input  req0_valid, req0_data1, req0_data2,
    input  req1_valid, req1_data1, req1_data2,
    input  unit_result, unit_vld,
    output req0_ready, req0_result, req0_vld,
    output req1_ready, req1_result, req1_vld,
    output unit_data1, unit_data2, unit_trig,
    output busy, err
  );

  modport master (
    output req0_valid, req0_data1, req0_data2,
    output req1_valid, req1_data1, req1_data2,
    output unit_result, unit_vld,
    input  req0_ready, req0_result, req0_vld,
    input  req1_ready, req1_result, req1_vld,
    input  unit_data1, unit_data2, unit_trig,
    input  busy, err
  );
endinterface

// File: rtl/mul_unit_arbiter.sv
// Round-robin arbiter sharing one multiplier unit between two requesters,
// with a wait timeout that returns NAN_WORD and flags err.
module mul_unit_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] NAN_WORD = 32'h7FC00000
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  mul_unit_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  // Last WAIT count at which a result is still accepted; pulse lands TIMEOUT cycles after unit_trig.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trig_q, trig_d;
  logic [31:0]        data1_q, data1_d;
  logic [31:0]        data2_q, data2_d;
  logic [31:0]        res0_q, res0_d;
  logic [31:0]        res1_q, res1_d;
  logic               vld0_q, vld0_d;
  logic               vld1_q, vld1_d;
  logic               err_q, err_d;

  logic               ready0_c, ready1_c;
  logic               done_c;
  logic [31:0]        done_val_c;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      trig_q       <= 1'b0;
      data1_q      <= '0;
      data2_q      <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
      vld0_q       <= 1'b0;
      vld1_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      trig_q       <= trig_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      vld0_q       <= vld0_d;
      vld1_q       <= vld1_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    trig_d       = 1'b0;
    data1_d      = data1_q;
    data2_d      = data2_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    vld0_d       = 1'b0;
    vld1_d       = 1'b0;
    err_d        = 1'b0;
    ready0_c     = 1'b0;
    ready1_c     = 1'b0;
    done_c       = 1'b0;
    done_val_c   = '0;

    unique case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time is served.
        ready0_c = bus.req0_valid & (~bus.req1_valid | last_grant_q);
        ready1_c = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
        if (ready0_c | ready1_c) begin
          owner_d      = ready1_c;
          last_grant_d = ready1_c;
          data1_d      = ready1_c ? bus.req1_data1 : bus.req0_data1;
          data2_d      = ready1_c ? bus.req1_data2 : bus.req0_data2;
          trig_d       = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving on the last tolerated cycle beats the timeout.
        if (bus.unit_vld) begin
          done_c     = 1'b1;
          done_val_c = bus.unit_result;
          state_d    = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done_c     = 1'b1;
          done_val_c = NAN_WORD;
          err_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (done_c) begin
      if (owner_q) begin
        res1_d = done_val_c;
        vld1_d = 1'b1;
      end else begin
        res0_d = done_val_c;
        vld0_d = 1'b1;
      end
    end
  end

  assign bus.req0_ready  = ready0_c;
  assign bus.req1_ready  = ready1_c;
  assign bus.req0_result = res0_q;
  assign bus.req1_result = res1_q;
  assign bus.req0_vld    = vld0_q;
  assign bus.req1_vld    = vld1_q;
  assign bus.unit_data1  = data1_q;
  assign bus.unit_data2  = data2_q;
  assign bus.unit_trig   = trig_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mul_unit_arbiter.sv
// Directed and randomized checks of mul_unit_arbiter against a transaction-level model
// that tracks each operation by its transfer cycle and acceptance window.
module tb_mul_unit_arbiter;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] NAN = 32'h7FC00000;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;

  always #5 sys_clk = ~sys_clk;

  mul_unit_arbiter_if bus();

  mul_unit_arbiter #(.TIMEOUT(TO), .NAN_WORD(NAN)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: an operation is described by owner and transfer cycle T; results are accepted
  // in cycles T+2 .. T+TO, and the abort lands at T+TO+1 (TO cycles after unit_trig).
  bit          m_busy;
  int          m_owner;
  int          m_T;
  int          m_last;
  logic [31:0] m_res [2];
  bit          e_vld [2];
  bit          e_err;
  bit          e_trig;
  logic [31:0] e_d1, e_d2;

  int          g_last;
  int          trig_cyc, err_cyc, err_cnt;
  int          vld_cnt [2];
  int          gq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int grant(input logic v0, input logic v1);
    if (v0 && v1) return (m_last == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy   = 0;
    m_owner  = 0;
    m_T      = -100;
    m_last   = 1;
    m_res[0] = '0;
    m_res[1] = '0;
    e_vld[0] = 0;
    e_vld[1] = 0;
    e_err    = 0;
    e_trig   = 0;
    e_d1     = '0;
    e_d2     = '0;
    g_last   = -1;
  endtask

  task automatic check_outputs(input int g);
    check("req0_ready",  32'(bus.req0_ready), 32'(g == 0));
    check("req1_ready",  32'(bus.req1_ready), 32'(g == 1));
    check("busy",        32'(bus.busy),       32'(m_busy));
    check("unit_trig",   32'(bus.unit_trig),  32'(e_trig));
    check("unit_data1",  bus.unit_data1,      e_d1);
    check("unit_data2",  bus.unit_data2,      e_d2);
    check("req0_vld",    32'(bus.req0_vld),   32'(e_vld[0]));
    check("req1_vld",    32'(bus.req1_vld),   32'(e_vld[1]));
    check("err",         32'(bus.err),        32'(e_err));
    check("req0_result", bus.req0_result,     m_res[0]);
    check("req1_result", bus.req1_result,     m_res[1]);
  endtask

  task automatic set_in(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                        input logic uv, input logic [31:0] ur);
    bus.req0_valid  = v0;
    bus.req0_data1  = a0;
    bus.req0_data2  = b0;
    bus.req1_valid  = v1;
    bus.req1_data1  = a1;
    bus.req1_data2  = b1;
    bus.unit_vld    = uv;
    bus.unit_result = ur;
  endtask

  // Check the current cycle, advance the model by one cycle, move to the next negedge.
  task automatic cycle();
    int g;
    bit nv0, nv1, nerr, ntrig;
    #1;
    g = m_busy ? -1 : grant(bus.req0_valid, bus.req1_valid);
    check_outputs(g);
    if (bus.unit_trig) trig_cyc = cyc;
    if (bus.err) begin err_cyc = cyc; err_cnt++; end
    if (bus.req0_vld) vld_cnt[0]++;
    if (bus.req1_vld) vld_cnt[1]++;
    nv0 = 0; nv1 = 0; nerr = 0; ntrig = 0;
    if (g >= 0) begin
      gq.push_back(g);
      m_busy  = 1;
      m_owner = g;
      m_T     = cyc;
      m_last  = g;
      e_d1    = (g == 1) ? bus.req1_data1 : bus.req0_data1;
      e_d2    = (g == 1) ? bus.req1_data2 : bus.req0_data2;
      ntrig   = 1;
    end else if (m_busy && cyc >= m_T + 2) begin
      if (bus.unit_vld) begin
        m_res[m_owner] = bus.unit_result;
        if (m_owner == 0) nv0 = 1; else nv1 = 1;
        m_busy = 0;
      end else if (cyc == m_T + int'(TO)) begin
        m_res[m_owner] = NAN;
        if (m_owner == 0) nv0 = 1; else nv1 = 1;
        nerr   = 1;
        m_busy = 0;
      end
    end
    e_vld[0] = nv0;
    e_vld[1] = nv1;
    e_err    = nerr;
    e_trig   = ntrig;
    g_last   = g;
    @(negedge sys_clk);
    cyc++;
  endtask

  // Assert reset at the current point, check reset values, release at the next negedge.
  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(grant(bus.req0_valid, bus.req1_valid));
    @(negedge sys_clk);
    cyc++;
    sys_rst_n = 1'b1;
    trig_cyc   = -100;
    err_cyc    = -100;
    err_cnt    = 0;
    vld_cnt[0] = 0;
    vld_cnt[1] = 0;
    gq.delete();
  endtask

  initial begin
    int          t0;
    bit          p0, p1;
    logic [31:0] a0, b0, a1, b1;

    set_in(0, '0, '0, 0, '0, '0, 0, '0);
    #2;
    do_reset();

    // Single requester 0 transaction with fixed latency.
    set_in(1, 32'h3F800000, 32'h40000000, 0, '0, '0, 0, '0);
    t0 = cyc;
    cycle();
    set_in(0, '0, '0, 0, '0, '0, 0, '0);
    while (cyc < t0 + 5) cycle();
    set_in(0, '0, '0, 0, '0, '0, 1, 32'h40000000);
    cycle();
    set_in(0, '0, '0, 0, '0, '0, 0, '0);
    check("single_res",  bus.req0_result, 32'h40000000);
    check("single_vld",  32'(bus.req0_vld), 32'd1);
    check("single_busy", 32'(bus.busy), 32'd0);
    check("single_trig_cyc", 32'(trig_cyc - t0), 32'd1);
    cycle();

    // Contention from reset: grants alternate starting with requester 0.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      set_in(1, 32'h11110000 + 32'(i), 32'h22220000, 1, 32'h33330000 + 32'(i), 32'h44440000,
             (m_busy && cyc == m_T + 4) ? 1'b1 : 1'b0, 32'hA5A50000 + 32'(i));
      cycle();
    end
    check("rr_count", 32'(gq.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      check($sformatf("rr_grant%0d", i), 32'(gq[i]), 32'(i % 2));

    // Timeout on requester 1: NaN and err exactly TO cycles after unit_trig.
    do_reset();
    set_in(0, '0, '0, 1, 32'h40400000, 32'h40800000, 0, '0);
    cycle();
    set_in(0, '0, '0, 0, '0, '0, 0, '0);
    for (int i = 0; i < 12; i++) cycle();
    check("to_delay",  32'(err_cyc - trig_cyc), 32'(TO));
    check("to_result", bus.req1_result, NAN);
    check("to_vld1",   32'(vld_cnt[1]), 32'd1);
    check("to_errcnt", 32'(err_cnt), 32'd1);

    // Result on the last tolerated cycle wins over the timeout.
    do_reset();
    set_in(1, 32'h1, 32'h2, 0, '0, '0, 0, '0);
    t0 = cyc;
    cycle();
    for (int i = 0; i < 12; i++) begin
      set_in(0, '0, '0, 0, '0, '0, (cyc == t0 + int'(TO)) ? 1'b1 : 1'b0, 32'h12345678);
      cycle();
    end
    check("race_result", bus.req0_result, 32'h12345678);
    check("race_err",    32'(err_cnt), 32'd0);
    check("race_vld0",   32'(vld_cnt[0]), 32'd1);

    // Reset while waiting, then a stray result after release.
    do_reset();
    set_in(1, 32'h5, 32'h6, 0, '0, '0, 0, '0);
    cycle();
    set_in(0, '0, '0, 0, '0, '0, 0, '0);
    cycle();
    cycle();
    do_reset();
    cycle();
    cycle();
    set_in(0, '0, '0, 0, '0, '0, 1, 32'hDEADBEEF);
    cycle();
    set_in(0, '0, '0, 0, '0, '0, 0, '0);
    for (int i = 0; i < 3; i++) cycle();
    check("rst_vld",  32'(vld_cnt[0] + vld_cnt[1]), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_res0", bus.req0_result, 32'd0);

    // Stray unit_vld in IDLE and in ISSUE, then a normal completion.
    do_reset();
    set_in(0, '0, '0, 0, '0, '0, 1, 32'h0BADF00D);
    cycle();
    set_in(1, 32'h7, 32'h8, 0, '0, '0, 0, '0);
    cycle();
    set_in(0, '0, '0, 0, '0, '0, 1, 32'h0BADF00D);
    cycle();
    set_in(0, '0, '0, 0, '0, '0, 0, '0);
    cycle();
    cycle();
    set_in(0, '0, '0, 0, '0, '0, 1, 32'hCAFEF00D);
    cycle();
    set_in(0, '0, '0, 0, '0, '0, 0, '0);
    cycle();
    check("stray_vld0",   32'(vld_cnt[0]), 32'd1);
    check("stray_result", bus.req0_result, 32'hCAFEF00D);
    check("stray_busy",   32'(bus.busy), 32'd0);

    // Randomized traffic: requesters hold until accepted, sometimes withdraw.
    do_reset();
    p0 = 0; p1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    for (int i = 0; i < 2000; i++) begin
      if (g_last == 0) p0 = 0;
      if (g_last == 1) p1 = 0;
      if (!p0 && ($urandom % 3) == 0) begin p0 = 1; a0 = $urandom; b0 = $urandom; end
      else if (p0 && ($urandom % 16) == 0) p0 = 0;
      if (!p1 && ($urandom % 3) == 0) begin p1 = 1; a1 = $urandom; b1 = $urandom; end
      else if (p1 && ($urandom % 16) == 0) p1 = 0;
      set_in(p0, a0, b0, p1, a1, b1, ($urandom % 5) == 0, $urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
